// File: rtl/pwm_capture_if.sv
// Signal bundle between a PWM source and pwm_capture: the raw input plus all measurement results.
interface pwm_capture_if #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned DUTY_W = 8
);
  logic              pwm_in;
  logic [CNT_W-1:0]  high_cnt;
  logic [CNT_W-1:0]  period_cnt;
  logic              valid;
  logic              ovf;
  logic [DUTY_W-1:0] duty;
  logic              duty_valid;
  logic              stuck;
  logic              level;

  modport master (
    output pwm_in,
    input  high_cnt, period_cnt, valid, ovf, duty, duty_valid, stuck, level
  );

  modport slave (
    input  pwm_in,
    output high_cnt, period_cnt, valid, ovf, duty, duty_valid, stuck, level
  );
endinterface

// File: rtl/pwm_capture.sv
// Measures high time and period of an asynchronous PWM input and derives an 8-bit-scale duty
// value with a serial restoring divider; flags a stuck input after a configurable timeout.
module pwm_capture #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned DUTY_W  = 8,
  parameter int unsigned TIMEOUT = 65535
) (
  input logic          clk,
  input logic          rst,
  pwm_capture_if.slave bus
);

  localparam int unsigned        DivCntW    = $clog2(DUTY_W + 1);
  localparam logic [CNT_W-1:0]   CntMax     = '1;
  localparam logic [CNT_W-1:0]   CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0]   TimeoutCnt = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0]   TimeoutM1  = CNT_W'(TIMEOUT - 1);
  localparam logic [DivCntW-1:0] DivIters   = DivCntW'(DUTY_W);
  localparam logic [DivCntW-1:0] DivOne     = DivCntW'(1);

  typedef enum logic [1:0] {StIdle, StHigh, StLow} state_e;

  state_e            r_state, w_state_nxt;
  logic              r_sync1, r_sync2, r_hist;
  logic              w_rise, w_fall, w_timeout;
  logic [CNT_W-1:0]  r_idle;
  logic              r_stuck;
  logic [CNT_W-1:0]  r_high_acc, r_per_acc, w_high_acc_nxt, w_per_acc_nxt;
  logic              r_sat, w_sat_nxt, w_publish;
  logic [CNT_W-1:0]  r_high_cnt, r_period_cnt;
  logic              r_valid, r_ovf;
  logic              r_div_busy;
  logic [DivCntW-1:0] r_div_cnt;
  logic [CNT_W:0]    r_rem, w_rem_shift, w_rem_step;
  logic [CNT_W-1:0]  r_divisor;
  logic [DUTY_W-1:0] r_quot, w_quot_step, r_duty;
  logic              r_duty_valid, w_ge;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= bus.pwm_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_rise    = r_sync2 & ~r_hist;
  assign w_fall    = ~r_sync2 & r_hist;
  // Fires once TIMEOUT edge-free cycles have elapsed; an edge in the same cycle wins.
  assign w_timeout = ~w_rise & ~w_fall & (r_idle >= TimeoutM1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idle  <= '0;
      r_stuck <= 1'b0;
    end else begin
      if (w_rise || w_fall) begin
        r_idle <= '0;
      end else if (r_idle < TimeoutCnt) begin
        r_idle <= r_idle + CntOne;
      end
      if (w_rise) begin
        r_stuck <= 1'b0;
      end else if (w_timeout) begin
        r_stuck <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_high_acc_nxt = r_high_acc;
    w_per_acc_nxt  = r_per_acc;
    w_sat_nxt      = r_sat;
    w_publish      = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_rise) begin
          w_state_nxt    = StHigh;
          w_high_acc_nxt = CntOne;
          w_per_acc_nxt  = CntOne;
          w_sat_nxt      = 1'b0;
        end
      end
      StHigh: begin
        if (r_per_acc == CntMax) w_sat_nxt = 1'b1;
        else                     w_per_acc_nxt = r_per_acc + CntOne;
        if (w_fall) begin
          w_state_nxt = StLow;
        end else if (r_high_acc == CntMax) begin
          w_sat_nxt = 1'b1;
        end else begin
          w_high_acc_nxt = r_high_acc + CntOne;
        end
      end
      StLow: begin
        if (w_rise) begin
          w_publish      = 1'b1;
          w_state_nxt    = StHigh;
          w_high_acc_nxt = CntOne;
          w_per_acc_nxt  = CntOne;
          w_sat_nxt      = 1'b0;
        end else if (r_per_acc == CntMax) begin
          w_sat_nxt = 1'b1;
        end else begin
          w_per_acc_nxt = r_per_acc + CntOne;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    if (w_timeout) w_state_nxt = StIdle;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_high_acc   <= '0;
      r_per_acc    <= '0;
      r_sat        <= 1'b0;
      r_valid      <= 1'b0;
      r_high_cnt   <= '0;
      r_period_cnt <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_high_acc <= w_high_acc_nxt;
      r_per_acc  <= w_per_acc_nxt;
      r_sat      <= w_sat_nxt;
      r_valid    <= w_publish;
      if (w_publish) begin
        r_high_cnt   <= r_high_acc;
        r_period_cnt <= r_per_acc;
        r_ovf        <= r_sat;
      end
    end
  end

  // Remainder stays below the divisor, so the doubled value always fits in CNT_W+1 bits.
  assign w_rem_shift = r_rem << 1;
  assign w_ge        = (w_rem_shift >= {1'b0, r_divisor});
  assign w_rem_step  = w_ge ? (w_rem_shift - {1'b0, r_divisor}) : w_rem_shift;
  assign w_quot_step = (r_quot << 1) | DUTY_W'(w_ge);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_div_busy   <= 1'b0;
      r_div_cnt    <= '0;
      r_rem        <= '0;
      r_divisor    <= '0;
      r_quot       <= '0;
      r_duty       <= '0;
      r_duty_valid <= 1'b0;
    end else begin
      r_duty_valid <= 1'b0;
      if (r_div_busy) begin
        r_rem     <= w_rem_step;
        r_quot    <= w_quot_step;
        r_div_cnt <= r_div_cnt - DivOne;
        if (r_div_cnt == DivOne) begin
          r_div_busy   <= 1'b0;
          r_duty       <= w_quot_step;
          r_duty_valid <= 1'b1;
        end
      end else if (r_valid && !r_ovf) begin
        r_div_busy <= 1'b1;
        r_div_cnt  <= DivIters;
        r_rem      <= {1'b0, r_high_cnt};
        r_divisor  <= r_period_cnt;
        r_quot     <= '0;
      end
    end
  end

  assign bus.high_cnt   = r_high_cnt;
  assign bus.period_cnt = r_period_cnt;
  assign bus.valid      = r_valid;
  assign bus.ovf        = r_ovf;
  assign bus.duty       = r_duty;
  assign bus.duty_valid = r_duty_valid;
  assign bus.stuck      = r_stuck;
  assign bus.level      = r_sync2;

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Measures an incoming PWM waveform: high time, period, and an 8-bit duty value on the same scale as the `pwm` generator's `cmp_reg`. Sits on the input side of the motor/servo path as the complement of `pwm`. Its uses are:

- closed-loop checking of our own PWM outputs;
- decoding externally driven PWM (RC receivers, sensor duty outputs).

Single clock domain. `pwm_in` is asynchronous.

## Interface
Parameters:
- CNT_W, 16, width of the high-time and period counters (cycles).
- DUTY_W, 8, width of the duty result.
- TIMEOUT, 65535, cycles without any edge before stuck is declared. Must be ≤ 2^CNT_W−1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- pwm_in  in  1  asynchronous PWM input.
- high_cnt  out  CNT_W  high time of the last complete period, in clk cycles.
- period_cnt  out  CNT_W  length of the last complete period (rise to rise), in clk cycles.
- valid  out  1  one-cycle pulse when high_cnt/period_cnt update.
- ovf  out  1  set with valid when either count saturated; cleared at the next valid.
- duty  out  DUTY_W  floor(high_cnt·2^DUTY_W / period_cnt).
- duty_valid  out  1  one-cycle pulse when duty updates.
- stuck  out  1  no edge for TIMEOUT cycles; cleared on the next rising edge.
- level  out  1  synchronized pwm_in level.

## Operation
- **Input synchronizer:** two flops, then one history flop.
  - rise = sync & ~hist; fall = ~sync & hist.
  - level = sync.
- **FSM states:** IDLE, HIGH, LOW. Reset enters IDLE.
  - IDLE: wait for rise. The first rise loads the accumulators (high_acc = 1, per_acc = 1) and moves to HIGH. No valid is produced.
  - HIGH: high_acc and per_acc increment each cycle. On fall: high_acc freezes, state moves to LOW.
  - LOW: per_acc increments each cycle. On rise: publish high_cnt ← high_acc, period_cnt ← per_acc, ovf ← saturation flag, and pulse valid. In the same cycle, reload the accumulators to 1 and move to HIGH.
- **Saturation:** accumulators stop at 2^CNT_W−1 and set an internal saturation flag. The flag is cleared on reload.
- **Timeout:**
  - An idle counter clears on every rise or fall and increments otherwise.
  - When it reaches TIMEOUT: stuck ← 1, state ← IDLE, idle counter holds.
  - No valid is produced. high_cnt, period_cnt and duty keep their old values.
  - stuck clears on the next rise, which also starts a new measurement as from IDLE.
- **Divider:** restoring, one quotient bit per cycle.
  - Starts on valid when ovf = 0 and the divider is idle.
  - Initialization: remainder = high_cnt (CNT_W+1 bits), divisor = period_cnt.
  - Each iteration: r ← 2r; if r ≥ divisor, then r −= divisor and the quotient bit = 1. Quotient bits are produced MSB first.
  - high < period always holds in a non-saturated measurement, so the result fits in DUTY_W bits.
  - A valid arriving while the divider is busy still updates high_cnt/period_cnt but does not restart or queue a division. That measurement's duty is dropped.
  - A valid with ovf = 1 starts no division.
- **Reset values:** every output 0, FSM in IDLE, divider idle. Reset in mid-measurement or mid-division discards everything.

## Timing
- Edge detection lags pwm_in by 2–3 cycles (synchronizer). The lag is identical for both edges, so counts are unaffected.
- **valid:** asserted in the cycle after the registered rise. high_cnt/period_cnt are stable from that cycle until the next valid.
- **duty_valid:** asserted exactly DUTY_W+1 cycles after valid (load cycle + DUTY_W iterations). duty holds until the next duty_valid.
- **Minimum measurable waveform:** high ≥ 1 cycle and low ≥ 1 cycle, measured after synchronization. Shorter pulses are not detected.
- **Simultaneous events:**
  - Timeout and rise in the same cycle: rise wins (no stuck).
  - Reset wins over everything.

## Test plan
- **Basic measurement:** pwm_in high 3 cycles, low 7, repeated. From the second period on: high_cnt = 3, period_cnt = 10, ovf = 0. duty = 76, with duty_valid 9 cycles after each valid.
- **Generator scale:** high 1 cycle, low 255 → high_cnt = 1, period_cnt = 256, duty = 1. Then high 128, low 128 → duty = 128.
- **Busy divider:** high 2, low 2 → valid every 4 cycles with 2/4. duty_valid only every 3rd valid (12-cycle spacing), duty = 128.
- **Timeout:** TIMEOUT = 100. Hold pwm_in high for 200 cycles → stuck = 1 and level = 1, no valid, old counts retained. A subsequent fall plus two full periods clears stuck and resumes valid.
- **Saturation:** CNT_W = 6, TIMEOUT = 63. high 40, low 40 → valid with period_cnt = 63, ovf = 1, no duty_valid. The next 10/20 period gives ovf = 0.
- **Reset mid-operation:** assert rst for 1 cycle during a HIGH phase and again during a division.
  - All outputs go to 0.
  - No valid until the second rise after reset.
  - No stale duty_valid appears.
